// File: rtl/mem_port_arbiter.sv
// Two-port single-memory arbiter: a read-only fetch port and a read/write data port
// share one memory. Round-robin arbitration, with an optional bounded data burst lock.
module mem_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  lock_e       lock_q, lock_d;
  logic [3:0]  cnt_q, cnt_d, cnt_next;
  logic        last_d_q;
  logic        force_f_q, force_f_d;
  logic        f_rv_q, d_rv_q;

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (lock_q == LOCKED && d_req && d_lock) begin
        d_gnt = 1'b1;
      end else if (force_f_q && f_req) begin
        f_gnt = 1'b1;
      end else if (f_req && d_req) begin
        if (last_d_q) f_gnt = 1'b1;
        else          d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // A burst that reaches MAX_BURST drops the lock and gives fetch one forced turn.
  always_comb begin
    cnt_next  = (lock_q == LOCKED) ? cnt_q + 4'd1 : 4'd1;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    force_f_d = 1'b0;
    if (d_gnt && d_lock) begin
      cnt_d = cnt_next;
      if (cnt_next >= MaxBurst) begin
        lock_d    = UNLOCKED;
        force_f_d = 1'b1;
      end else begin
        lock_d = LOCKED;
      end
    end else if (lock_q == LOCKED) begin
      lock_d = UNLOCKED;
      cnt_d  = 4'd0;
    end
  end

  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_addr  = f_addr;
      mem_wdata = d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= UNLOCKED;
      cnt_q     <= 4'd0;
      last_d_q  <= 1'b1;
      force_f_q <= 1'b0;
      f_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      force_f_q <= force_f_d;
      if (f_gnt || d_gnt) last_d_q <= d_gnt;
      f_rv_q    <= f_gnt;
      d_rv_q    <= d_gnt & ~d_we;
    end
  end

  // Read response is also masked while rst is high so a reset drops it immediately.
  assign f_rvalid = f_rv_q & ~rst;
  assign d_rvalid = d_rv_q & ~rst;
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              f_req = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic              f_gnt, f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
    d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 9'd3;
    tick(); tick();
    #1;
    n_checks++; if (f_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_fgnt: got %b want 0", f_gnt); end
    n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dgnt: got %b want 0", d_gnt); end
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {f_rvalid, d_rvalid}); end
    n_checks++; if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", f_rdata, d_rdata); end
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch_read();
    do_reset();
    f_req = 1'b1; f_addr = 9'd5;
    #1;
    n_checks++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL fr_fgnt: got %b want 1", f_gnt); end
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL fr_mem_en: got %b want 1", mem_en); end
    n_checks++; if (mem_addr !== 9'd5) begin n_fail++; $display("FAIL fr_mem_addr: got %0d want 5", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fr_mem_we: got %b want 0", mem_we); end
    tick();
    f_req = 1'b0; mem_rdata = 32'h5C100064;
    #1;
    n_checks++; if (f_rvalid !== 1'b1) begin n_fail++; $display("FAIL fr_rvalid: got %b want 1", f_rvalid); end
    n_checks++; if (f_rdata !== 32'h5C100064) begin n_fail++; $display("FAIL fr_rdata: got %h want 5c100064", f_rdata); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fr_d_rvalid: got %b want 0", d_rvalid); end
    tick();
    #1;
    n_checks++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL fr_rvalid_end: got %b want 0", f_rvalid); end
    n_checks++; if (f_rdata !== 32'h0) begin n_fail++; $display("FAIL fr_rdata_end: got %h want 0", f_rdata); end
    mem_rdata = '0;
  endtask

  task automatic test_round_robin();
    logic exp_f, prev_f;
    do_reset();
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 9'd1; d_addr = 9'd2;
    mem_rdata = 32'hA5A5_0001;
    prev_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_f = (i % 2 == 0);
      #1;
      n_checks++; if ({f_gnt, d_gnt} !== {exp_f, ~exp_f}) begin n_fail++; $display("FAIL rr_gnt%0d: got f%b d%b want f%b d%b", i, f_gnt, d_gnt, exp_f, ~exp_f); end
      if (i > 0) begin
        n_checks++; if ({f_rvalid, d_rvalid} !== {prev_f, ~prev_f}) begin n_fail++; $display("FAIL rr_rvalid%0d: got f%b d%b want f%b d%b", i, f_rvalid, d_rvalid, prev_f, ~prev_f); end
      end
      prev_f = exp_f;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'd100; d_wdata = 32'd90;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_dgnt: got %b want 1", d_gnt); end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
    n_checks++; if (mem_addr !== 9'd100) begin n_fail++; $display("FAIL wr_mem_addr: got %0d want 100", mem_addr); end
    n_checks++; if (mem_wdata !== 32'd90) begin n_fail++; $display("FAIL wr_mem_wdata: got %0d want 90", mem_wdata); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid: got %b want 0", d_rvalid); end
    n_checks++; if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL wr_idle_en: got %b want 00", {mem_en, mem_we}); end
    n_checks++; if (mem_addr !== 9'd0 || mem_wdata !== 32'd0) begin n_fail++; $display("FAIL wr_idle_bus: got %0d/%0d want 0/0", mem_addr, mem_wdata); end
  endtask

  task automatic test_lock_burst();
    logic [6:0] exp_d;
    exp_d = 7'b1101111; // bit i = expected d_gnt in cycle i
    do_reset();
    d_req = 1'b1; d_lock = 1'b1; d_addr = 9'd40;
    for (int i = 0; i < 7; i++) begin
      f_req = (i != 0);
      #1;
      n_checks++; if ({f_gnt, d_gnt} !== {~exp_d[i], exp_d[i]}) begin n_fail++; $display("FAIL lock_gnt%0d: got f%b d%b want f%b d%b", i, f_gnt, d_gnt, ~exp_d[i], exp_d[i]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock_release();
    do_reset();
    d_req = 1'b1; d_lock = 1'b1;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rel_first: got %b want 1", d_gnt); end
    tick();
    f_req = 1'b1; d_lock = 1'b0;
    #1;
    n_checks++; if ({f_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL rel_rr: got f%b d%b want f1 d0", f_gnt, d_gnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_burst_no_fetch();
    do_reset();
    d_req = 1'b1; d_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL nof_dgnt%0d: got %b want 1", i, d_gnt); end
      tick();
    end
    f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({f_gnt, d_gnt} !== ((i == 2) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL nof_tail%0d: got f%b d%b want %s", i, f_gnt, d_gnt, (i == 2) ? "f" : "d"); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midread();
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'd7; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL mr_dgnt: got %b want 1", d_gnt); end
    tick();
    rst = 1'b1; d_req = 1'b0;
    #1;
    n_checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL mr_rvalid_rst: got %b want 00", {f_rvalid, d_rvalid}); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL mr_rdata_rst: got %h want 0", d_rdata); end
    tick();
    rst = 1'b0; f_req = 1'b1; d_req = 1'b1;
    #1;
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_rvalid_after: got %b want 0", d_rvalid); end
    n_checks++; if ({f_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL mr_first_gnt: got f%b d%b want f1 d0", f_gnt, d_gnt); end
    tick();
    idle_inputs();
    mem_rdata = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_fetch_read();
    test_round_robin();
    test_write();
    test_lock_burst();
    test_lock_release();
    test_burst_no_fetch();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width (512 words).
REQ-002 Parameter DATA_W, default 32, memory word width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive locked data grants, range 1..15.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Port list:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch address.
- f_gnt  out  1  fetch granted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data-port request.
- d_we  in  1  data-port write (1) / read (0).
- d_lock  in  1  data-port burst lock request.
- d_addr  in  ADDR_W  data-port address.
- d_wdata  in  DATA_W  data-port write data.
- d_gnt  out  1  data port granted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  DATA_W  data read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read access.

Function
REQ-006 At most one of f_gnt, d_gnt SHALL be 1 in any cycle; a grant SHALL only be issued to an asserted request.
REQ-007 Grants SHALL be combinational from the current requests and registered state; a requester holding its request low SHALL never be granted.
REQ-008 Single request: the sole requester SHALL be granted the same cycle.
REQ-009 Both requesting and no lock active: round-robin; the port not granted most recently SHALL win; the last-winner register updates on every grant.
REQ-010 Memory side SHALL mirror the winner combinationally: mem_en=1, mem_addr=winner address; mem_we=d_gnt&d_we; mem_wdata=d_wdata; with no grant, mem_en=0, mem_we=0, mem_addr=0, and mem_wdata=0.
REQ-011 Fetch is read-only; f_gnt SHALL never cause mem_we=1.
REQ-012 Read latency SHALL be exactly 1 cycle: a granted read in cycle N SHALL give rvalid=1 for that port in cycle N+1 only, with rdata=mem_rdata.
REQ-013 Granted writes SHALL produce no rvalid.
REQ-014 f_rdata and d_rdata SHALL be 0 whenever the corresponding rvalid is 0.
REQ-015 Lock states: UNLOCKED and LOCKED.
- UNLOCKED -> LOCKED on a data grant with d_lock=1; the burst counter is set to 1.
- In LOCKED, data SHALL win over fetch while d_req&d_lock; each data grant increments the counter.
REQ-016 LOCKED -> UNLOCKED occurs in either case:
- d_req=0 or d_lock=0 in any cycle; the fetch port SHALL then be arbitrated by the normal round-robin.
- the counter reaches MAX_BURST; the next cycle SHALL grant fetch if f_req=1 (forced fairness), otherwise it SHALL be arbitrated normally.
REQ-017 When the counter reaches MAX_BURST and f_req=0, data MAY be re-granted and SHALL re-enter LOCKED with the counter set to 1.
REQ-018 Requests and address or data inputs SHALL be sampled only in the cycle they are granted; ungranted requests SHALL be re-presented by the requester.

Reset
REQ-019 With rst=1 at a clock edge, the following SHALL be reset:
- f_rvalid and d_rvalid to 0.
- f_rdata and d_rdata to 0.
- lock state to UNLOCKED and burst counter to 0.
- last-winner to data, so fetch wins the first contended cycle.
REQ-020 While rst=1, f_gnt, d_gnt, mem_en and mem_we SHALL be 0 regardless of requests.
REQ-021 Reset asserted mid-burst or with a read outstanding SHALL discard the pending rvalid, and the next cycle SHALL show rvalid=0.

Verification
REQ-022 After reset, f_req=1 with f_addr=5 and mem_rdata=0x5C100064 the next cycle -> f_gnt=1 and mem_en=1 in the grant cycle, then f_rvalid=1 with f_rdata=0x5C100064, then f_rvalid=0.
REQ-023 f_req=d_req=1 held for 4 cycles after reset -> grants alternate f,d,f,d; no cycle has both grants.
REQ-024 d_req=1, d_we=1, d_addr=100, d_wdata=90 -> d_gnt=1, mem_we=1, mem_addr=100, mem_wdata=90, no d_rvalid.
REQ-025 MAX_BURST=4, d_lock=1 and d_req, f_req held high, data granted first -> 4 consecutive d_gnt, then one f_gnt, then data relocks.
REQ-026 rst=1 in the cycle after a granted read -> f_rvalid=0 and d_rvalid=0; a request in the cycle after reset is granted per REQ-019.
